// File: rtl/proxy_allocator.sv
// Binds faulty systolic-array columns to a small shared pool of spare proxy PEs.
// Columns are scanned round-robin after each self-test; bindings hold until the next weight reload.
module proxy_allocator #(
    parameter int COLS        = 4,
    parameter int ROWS        = 4,
    parameter int NUM_PROXIES = 2,
    localparam int ROW_WIDTH  = $clog2(ROWS),
    localparam int COL_WIDTH  = $clog2(COLS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             STW_complete,
    input  logic [COLS-1:0]                  col_fault_detected,
    input  logic [COLS*ROW_WIDTH-1:0]        col_fault_idx,
    input  logic                             weights_reload,
    output logic [COLS-1:0]                  proxy_map_done,
    output logic [NUM_PROXIES-1:0]           proxy_busy,
    output logic [NUM_PROXIES*COL_WIDTH-1:0] proxy_col_sel,
    output logic [NUM_PROXIES*ROW_WIDTH-1:0] proxy_row_sel,
    output logic                             unmapped_fault,
    output logic                             alloc_done
);

    // state  | meaning
    // IDLE   | no mappings; waiting for a self-test result
    // SCAN   | evaluating one column per cycle, starting at rr_ptr
    // DONE   | scan finished; alloc_done high, round-robin pointer advances
    // MAPPED | mappings held until weights_reload
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DONE   = 2'd2,
        MAPPED = 2'd3
    } state_t;

    localparam int PROXY_WIDTH = (NUM_PROXIES > 1) ? $clog2(NUM_PROXIES) : 1;

    state_t                 state;
    state_t                 state_next;
    logic [COL_WIDTH-1:0]   rr_ptr;
    logic [COL_WIDTH-1:0]   scan_idx;
    logic [COL_WIDTH-1:0]   scan_cnt;
    logic [COL_WIDTH-1:0]   last_grant;
    logic                   granted;
    logic                   free_found;
    logic [PROXY_WIDTH-1:0] free_idx;
    logic                   cur_fault;
    logic [ROW_WIDTH-1:0]   cur_row;
    logic                   scan_last;

    function automatic logic [COL_WIDTH-1:0] wrap_inc(input logic [COL_WIDTH-1:0] v);
        return (v == COL_WIDTH'(COLS - 1)) ? '0 : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        free_found = 1'b0;
        free_idx   = '0;
        cur_fault  = col_fault_detected[scan_idx];
        cur_row    = col_fault_idx[int'(scan_idx)*ROW_WIDTH +: ROW_WIDTH];
        scan_last  = (scan_cnt == COL_WIDTH'(COLS - 1));

        // Walk downward so the lowest-index free proxy wins.
        for (int p = NUM_PROXIES - 1; p >= 0; p--) begin
            if (!proxy_busy[p]) begin
                free_found = 1'b1;
                free_idx   = PROXY_WIDTH'(p);
            end
        end

        case (state)
            IDLE:    if (STW_complete && !weights_reload) state_next = SCAN;
            SCAN:    if (weights_reload) state_next = IDLE;
                     else if (scan_last) state_next = DONE;
            DONE:    state_next = weights_reload ? IDLE : MAPPED;
            MAPPED:  if (weights_reload) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            scan_idx       <= '0;
            scan_cnt       <= '0;
            last_grant     <= '0;
            granted        <= 1'b0;
            proxy_map_done <= '0;
            proxy_busy     <= '0;
            proxy_col_sel  <= '0;
            proxy_row_sel  <= '0;
            unmapped_fault <= 1'b0;
            alloc_done     <= 1'b0;
        end else begin
            alloc_done <= 1'b0;
            if (weights_reload) begin
                // Release the pool from any state; rr_ptr survives so the next scan stays fair.
                proxy_map_done <= '0;
                proxy_busy     <= '0;
                proxy_col_sel  <= '0;
                proxy_row_sel  <= '0;
                unmapped_fault <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (STW_complete) begin
                            scan_idx <= rr_ptr;
                            scan_cnt <= '0;
                            granted  <= 1'b0;
                        end
                    end
                    SCAN: begin
                        if (cur_fault) begin
                            if (free_found) begin
                                proxy_busy[free_idx]                                   <= 1'b1;
                                proxy_col_sel[int'(free_idx)*COL_WIDTH +: COL_WIDTH]   <= scan_idx;
                                proxy_row_sel[int'(free_idx)*ROW_WIDTH +: ROW_WIDTH]   <= cur_row;
                                proxy_map_done[scan_idx]                               <= 1'b1;
                                last_grant                                             <= scan_idx;
                                granted                                                <= 1'b1;
                            end else begin
                                unmapped_fault <= 1'b1;
                            end
                        end
                        scan_idx   <= wrap_inc(scan_idx);
                        scan_cnt   <= scan_cnt + 1'b1;
                        alloc_done <= scan_last;
                    end
                    DONE: begin
                        if (granted) rr_ptr <= wrap_inc(last_grant);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_proxy_allocator.sv
// Directed bench for proxy_allocator: expected mappings are queued when a scan is
// launched and compared against the outputs when alloc_done appears.
module tb_proxy_allocator;

    localparam int COLS  = 4;
    localparam int ROWS  = 4;
    localparam int NP    = 2;
    localparam int RW    = 2;
    localparam int CW    = 2;
    localparam int ST_IDLE   = 0;
    localparam int ST_MAPPED = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              STW_complete;
    logic [COLS-1:0]   col_fault_detected;
    logic [COLS*RW-1:0] col_fault_idx;
    logic              weights_reload;
    logic [COLS-1:0]   proxy_map_done;
    logic [NP-1:0]     proxy_busy;
    logic [NP*CW-1:0]  proxy_col_sel;
    logic [NP*RW-1:0]  proxy_row_sel;
    logic              unmapped_fault;
    logic              alloc_done;

    typedef struct {
        logic [3:0] map_done;
        logic [1:0] busy;
        logic [3:0] col_sel;
        logic [3:0] row_sel;
        logic       unmapped;
        logic [1:0] rr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    proxy_allocator #(.COLS(COLS), .ROWS(ROWS), .NUM_PROXIES(NP)) dut (
        .clk                (clk),
        .rst                (rst),
        .STW_complete       (STW_complete),
        .col_fault_detected (col_fault_detected),
        .col_fault_idx      (col_fault_idx),
        .weights_reload     (weights_reload),
        .proxy_map_done     (proxy_map_done),
        .proxy_busy         (proxy_busy),
        .proxy_col_sel      (proxy_col_sel),
        .proxy_row_sel      (proxy_row_sel),
        .unmapped_fault     (unmapped_fault),
        .alloc_done         (alloc_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_outs"}, 32'({proxy_map_done, proxy_busy, proxy_col_sel, proxy_row_sel,
                                 unmapped_fault, alloc_done}), 32'd0);
        chk({tag, "_state"}, 32'(dut.state), ST_IDLE);
    endtask

    task automatic expect_scan(input logic [3:0] m, input logic [1:0] b, input logic [3:0] cs,
                               input logic [3:0] rs, input logic u, input logic [1:0] rr);
        exp_t e;
        e.map_done = m; e.busy = b; e.col_sel = cs; e.row_sel = rs; e.unmapped = u; e.rr = rr;
        sb_q.push_back(e);
    endtask

    task automatic run_scan(input string tag, input logic [3:0] faults, input logic [7:0] idx);
        int   edges;
        exp_t e;
        col_fault_detected = faults;
        col_fault_idx      = idx;
        STW_complete       = 1'b1;
        tick();
        STW_complete = 1'b0;
        edges = 1;
        while (!alloc_done && edges < 20) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(COLS + 1));
        e = sb_q.pop_front();
        chk({tag, "_map_done"}, 32'(proxy_map_done), 32'(e.map_done));
        chk({tag, "_busy"},     32'(proxy_busy),     32'(e.busy));
        chk({tag, "_col_sel"},  32'(proxy_col_sel),  32'(e.col_sel));
        chk({tag, "_row_sel"},  32'(proxy_row_sel),  32'(e.row_sel));
        chk({tag, "_unmapped"}, 32'(unmapped_fault), 32'(e.unmapped));
        tick();
        chk({tag, "_done_pulse"}, 32'(alloc_done), 32'd0);
        chk({tag, "_rr_ptr"},     32'(dut.rr_ptr), 32'(e.rr));
        chk({tag, "_state"},      32'(dut.state),  ST_MAPPED);
    endtask

    task automatic do_reload(input string tag);
        weights_reload = 1'b1;
        tick();
        weights_reload = 1'b0;
        chk_cleared(tag);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            tick();
            seen |= alloc_done;
        end
        chk({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        STW_complete       = 1'b0;
        weights_reload     = 1'b0;
        col_fault_detected = '0;
        col_fault_idx      = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_cleared("reset");
        chk("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // No faults: nothing bound, pointer stays put.
        expect_scan(4'b0000, 2'b00, 4'h0, 4'h0, 1'b0, 2'd0);
        run_scan("nofault", 4'b0000, 8'h00);
        do_reload("nofault_rel");

        // Cols 1 (row 2) and 3 (row 0).
        expect_scan(4'b1010, 2'b11, {2'd3, 2'd1}, {2'd0, 2'd2}, 1'b0, 2'd0);
        run_scan("two", 4'b1010, {2'd0, 2'd0, 2'd2, 2'd0});
        do_reload("two_rel");

        // Oversubscription, then fairness on the rescan.
        expect_scan(4'b0011, 2'b11, {2'd1, 2'd0}, {2'd3, 2'd1}, 1'b1, 2'd2);
        run_scan("over1", 4'b1111, {2'd1, 2'd2, 2'd3, 2'd1});
        do_reload("over_rel");
        expect_scan(4'b1100, 2'b11, {2'd3, 2'd2}, {2'd1, 2'd2}, 1'b1, 2'd0);
        run_scan("over2", 4'b1111, {2'd1, 2'd2, 2'd3, 2'd1});

        // A new self-test while mapped must be ignored.
        col_fault_detected = 4'b0001;
        col_fault_idx      = 8'h00;
        STW_complete       = 1'b1;
        tick();
        STW_complete = 1'b0;
        watch_no_done("mapped_ign", 6);
        chk("mapped_ign_hold", 32'({proxy_map_done, proxy_busy, proxy_col_sel, proxy_row_sel}),
            32'({4'b1100, 2'b11, 4'b1110, 4'b0110}));
        chk("mapped_ign_state", 32'(dut.state), ST_MAPPED);
        do_reload("mapped_rel");

        // Reload two cycles into a scan aborts it.
        col_fault_detected = 4'b0001;
        col_fault_idx      = 8'h00;
        STW_complete       = 1'b1;
        tick();
        STW_complete = 1'b0;
        tick();
        chk("abort_pre_map", 32'(proxy_map_done), 32'b0001);
        do_reload("abort");
        watch_no_done("abort", 6);
        chk("abort_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // Simultaneous start and reload in IDLE: reload wins.
        STW_complete   = 1'b1;
        weights_reload = 1'b1;
        tick();
        STW_complete   = 1'b0;
        weights_reload = 1'b0;
        chk_cleared("simul");
        watch_no_done("simul", 6);

        // Advance rr_ptr to 1, then hit reset mid-scan.
        expect_scan(4'b0001, 2'b01, 4'h0, 4'h0, 1'b0, 2'd1);
        run_scan("pre_rst", 4'b0001, 8'h00);
        do_reload("pre_rst_rel");
        col_fault_detected = 4'b0100;
        col_fault_idx      = {2'd0, 2'd3, 2'd0, 2'd0};
        STW_complete       = 1'b1;
        tick();
        STW_complete = 1'b0;
        tick();
        tick();
        chk("rst_pre_map", 32'({proxy_map_done, proxy_busy, proxy_row_sel}),
            32'({4'b0100, 2'b01, 4'b0011}));
        rst = 1'b1;
        tick();
        chk_cleared("scan_rst");
        chk("scan_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("scan_rst_scan_idx", 32'(dut.scan_idx), 32'd0);
        rst = 1'b0;
        watch_no_done("scan_rst", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/proxy_allocator.md
# proxy_allocator

Shares a small pool of spare proxy PEs among the columns of the systolic array. After a STW self-test pass, it scans the per-column fault flags in round-robin order and binds each faulty column to a free proxy. It then drives that column's `proxy_map_done` and each proxy's column/row select. Mappings persist until new weights are loaded, at which point the pool is released.

## Interface
- `COLS`, 4, number of array columns (each has one proxy_controller)
- `ROWS`, 4, number of PE rows per column
- `NUM_PROXIES`, 2, number of proxy PEs in the shared pool (1..COLS)
- Derived: `ROW_WIDTH = $clog2(ROWS)`, `COL_WIDTH = $clog2(COLS)`

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `STW_complete`  in  1  one-cycle pulse: STW results and fault flags are valid
- `col_fault_detected`  in  COLS  per-column fault flag (bit c = column c)
- `col_fault_idx`  in  COLS*ROW_WIDTH  priority faulty row per column; slice c = column c
- `weights_reload`  in  1  one-cycle pulse: new stationary weights coming; release all mappings
- `proxy_map_done`  out  COLS  column c has a proxy bound (sticky)
- `proxy_busy`  out  NUM_PROXIES  proxy p is bound
- `proxy_col_sel`  out  NUM_PROXIES*COL_WIDTH  column served by proxy p
- `proxy_row_sel`  out  NUM_PROXIES*ROW_WIDTH  faulty row replaced by proxy p
- `unmapped_fault`  out  1  sticky: at least one faulty column got no proxy
- `alloc_done`  out  1  one-cycle pulse: scan finished, mappings stable

## Operation
- States: IDLE, SCAN, DONE, MAPPED.
- IDLE:
  - `STW_complete`=1 and `weights_reload`=0 -> SCAN; load `scan_idx <= rr_ptr` and `scan_cnt <= 0`.
  - `weights_reload` wins if both are high; stay in IDLE.
- SCAN, evaluating column `scan_idx` each cycle:
  - If `col_fault_detected[scan_idx]` and a free proxy exists: take the lowest-index free proxy p. Set `proxy_busy[p]`, `proxy_col_sel[p] <= scan_idx`, `proxy_row_sel[p] <= col_fault_idx[scan_idx]`, `proxy_map_done[scan_idx] <= 1`. Record `last_grant <= scan_idx`.
  - If faulty and no proxy is free: `unmapped_fault <= 1`; the column stays unmapped.
  - `scan_idx` increments modulo COLS (wraps COLS-1 -> 0). `scan_cnt` increments.
  - When `scan_cnt == COLS-1` -> DONE.
- DONE: `alloc_done`=1 for exactly one cycle. If any grant was made this scan, `rr_ptr <= (last_grant+1) mod COLS`; otherwise `rr_ptr` is unchanged. -> MAPPED.
- MAPPED: hold all mappings. Ignore `STW_complete`. `weights_reload` -> IDLE and clears `proxy_map_done`, `proxy_busy`, `proxy_col_sel`, `proxy_row_sel`, `unmapped_fault`. `rr_ptr` is retained.
- `weights_reload` during SCAN or DONE aborts the scan: clear the same state as above, go to IDLE, leave `rr_ptr` unchanged, and do not pulse `alloc_done`.
- Fault inputs are sampled only in the SCAN cycle of their column. Later changes do not alter existing mappings.
- Fault state is never duplicated: a column holds at most one proxy.

## Timing
- Reset values: state=IDLE; `rr_ptr`, `scan_idx`, `scan_cnt`, `last_grant` = 0; every output = 0.
- Reset mid-SCAN or mid-MAPPED returns everything to the reset values on the next edge.
- `STW_complete` sampled high at edge T0:
  - Column evaluations occur in cycles T0..T0+COLS-1.
  - Each grant is visible on the outputs from the edge that ends its evaluation cycle.
  - `alloc_done` is high during cycle T0+COLS, i.e. latency COLS+1 edges from the `STW_complete` edge.
- `proxy_map_done[c]` rises exactly once per allocation and never glitches low while in MAPPED.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
Defaults COLS=4, NUM_PROXIES=2.
- No faults: `col_fault_detected`=4'b0000, pulse `STW_complete` -> `alloc_done` pulses 5 edges later; `proxy_map_done`=0, `proxy_busy`=0, `unmapped_fault`=0, `rr_ptr` stays 0.
- Two faults: cols 1 and 3 faulty, `col_fault_idx` = row 2 for col 1 and row 0 for col 3 -> proxy0 = (col 1, row 2), proxy1 = (col 3, row 0); `proxy_map_done`=4'b1010; `unmapped_fault`=0; `rr_ptr`=0 after DONE.
- Oversubscription: all 4 columns faulty -> cols 0 and 1 mapped, `proxy_map_done`=4'b0011, `unmapped_fault`=1, `rr_ptr`=2. Then `weights_reload`, then `STW_complete` with the same faults -> cols 2 and 3 mapped (`proxy_map_done`=4'b1100), `rr_ptr`=0.
- Reload mid-scan: `weights_reload` 2 cycles after `STW_complete` with col 0 faulty -> all outputs 0 next edge, no `alloc_done`, state IDLE.
- Ignore in MAPPED: `STW_complete` with different faults while MAPPED -> mappings unchanged, no `alloc_done`.
- Simultaneous `STW_complete` and `weights_reload` in IDLE -> stays IDLE, outputs 0; sync `rst` asserted in SCAN -> all outputs 0 and `rr_ptr`=0 next edge.
